// File: rtl/period_meter.sv
// Measures the distance in clk cycles between rising edges of tickIn and hands each
// captured period to a consumer over a valid/ready pair, with lock and overflow status.
module period_meter #(
   parameter int WIDTH      = 11,
   parameter int LOCK_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tickIn,
   output logic [WIDTH-1:0] period,
   output logic             periodValid,
   input  logic             periodReady,
   output logic             locked,
   output logic             overflow,
   output logic             dropped,
   output logic [1:0]       state_dbg_o
);

   // Handshake: a capture is handed over when periodValid and periodReady are both
   // high at a clk edge; period is stable while periodValid is high unless a newer
   // capture overwrites it, in which case dropped pulses for one cycle.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEAS = 2'd1,
      ST_OVF  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             overflow_q, overflow_d;
   logic             dropped_q, dropped_d;
   logic [3:0]       match_q, match_d;
   logic             tick_prev_q;

   logic             rise;
   logic             capture;
   logic             count_at_max;
   logic [3:0]       match_next;

   assign rise         = tickIn & ~tick_prev_q;
   assign capture      = (state_q == ST_MEAS) && rise;
   assign count_at_max = (count_q == CNT_MAX);

   // Match count restarts on the first capture of a run (match_q cleared) or on change.
   always_comb begin
      if ((match_q == 4'd0) || (count_q != period_q)) begin
         match_next = 4'd1;
      end else if (match_q >= LOCK_N) begin
         match_next = LOCK_N;
      end else begin
         match_next = match_q + 4'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      period_d   = period_q;
      valid_d    = valid_q;
      locked_d   = locked_q;
      overflow_d = overflow_q;
      dropped_d  = 1'b0;
      match_d    = match_q;

      case (state_q)
         ST_IDLE, ST_OVF: begin
            if (rise) begin
               state_d = ST_MEAS;
               count_d = CNT_ONE;
            end
         end
         ST_MEAS: begin
            if (rise) begin
               count_d = CNT_ONE;
            end else if (count_at_max) begin
               state_d    = ST_OVF;
               overflow_d = 1'b1;
               match_d    = 4'd0;
               locked_d   = 1'b0;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture) begin
         period_d  = count_q;
         valid_d   = 1'b1;
         dropped_d = valid_q & ~periodReady;
         match_d   = match_next;
         locked_d  = (match_next >= LOCK_N);
      end else if (valid_q && periodReady) begin
         valid_d = 1'b0;
      end
   end

   // tick_prev_q resets high so a level already present at reset release is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         overflow_q  <= 1'b0;
         dropped_q   <= 1'b0;
         match_q     <= 4'd0;
         tick_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         overflow_q  <= overflow_d;
         dropped_q   <= dropped_d;
         match_q     <= match_d;
         tick_prev_q <= tickIn;
      end
   end

   assign period      = period_q;
   assign periodValid = valid_q;
   assign locked      = locked_q;
   assign overflow    = overflow_q;
   assign dropped     = dropped_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter at WIDTH=4: directed scenarios plus random ticks, checked every
// cycle against a model built on rise timestamps and gap arithmetic.
module tb_period_meter;

   localparam int W    = 4;
   localparam int LOCK = 3;
   localparam int MAXP = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tick_in = 1'b0;
   logic         period_ready = 1'b0;
   logic [W-1:0] period;
   logic         period_valid;
   logic         locked;
   logic         overflow;
   logic         dropped;
   logic [1:0]   state_dbg;
   logic [W+3:0] obs_vec;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: timestamps of rises and the gap between them.
   int cyc = 0;
   bit m_tprev;
   bit m_armed;
   int m_last;
   int m_period;
   int m_match;
   bit m_valid, m_locked, m_ovf, m_dropped;

   always #5 clk = ~clk;

   period_meter #(.WIDTH(W), .LOCK_COUNT(LOCK)) dut (
      .clk        (clk),
      .rst        (rst),
      .tickIn     (tick_in),
      .period     (period),
      .periodValid(period_valid),
      .periodReady(period_ready),
      .locked     (locked),
      .overflow   (overflow),
      .dropped    (dropped),
      .state_dbg_o(state_dbg)
   );

   assign obs_vec = {period, period_valid, locked, overflow, dropped};

   function automatic logic [W+3:0] exp_vec();
      return {W'(m_period), m_valid, m_locked, m_ovf, m_dropped};
   endfunction

   task automatic model_edge(input bit t, input bit r, input bit rs);
      bit rise;
      int gap;
      cyc++;
      rise      = t && !m_tprev;
      m_dropped = 1'b0;
      if (rs) begin
         m_tprev = 1'b1; m_armed = 1'b0; m_period = 0; m_match = 0;
         m_valid = 1'b0; m_locked = 1'b0; m_ovf = 1'b0;
      end else begin
         m_tprev = t;
         if (rise && m_armed) begin
            gap       = cyc - m_last;
            m_dropped = m_valid && !r;
            if (m_match == 0 || gap != m_period) m_match = 1;
            else m_match = (m_match + 1 > LOCK) ? LOCK : m_match + 1;
            m_locked = (m_match >= LOCK);
            m_period = gap;
            m_valid  = 1'b1;
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
         if (rise) begin
            m_armed = 1'b1;
            m_last  = cyc;
         end else if (m_armed && (cyc - m_last) == MAXP) begin
            m_ovf = 1'b1; m_armed = 1'b0; m_match = 0; m_locked = 1'b0;
         end
      end
   endtask

   task automatic step(input logic t, input logic r, input logic rs);
      tick_in      = t;
      period_ready = r;
      rst          = rs;
      @(posedge clk);
      model_edge(t, r, rs);
      #1;
   endtask

   task automatic do_reset(input logic r);
      step(1'b0, r, 1'b1);
      step(1'b0, r, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (obs_vec !== '0 || state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL reset: got outs=%h state=%0d, expected outs=0 state=0", obs_vec, state_dbg);
      end
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec !== exp_vec() || state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_level_high: got outs=%h state=%0d, expected outs=%h state=0",
                  obs_vec, state_dbg, exp_vec());
      end
   endtask

   task automatic test_steady();
      bit drop_seen = 1'b0;
      do_reset(1'b1);
      for (int i = 0; i < 25; i++) begin
         step(i % 5 == 0, 1'b1, 1'b0);
         drop_seen |= dropped;
         n_checks++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL steady cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec());
         end
         if (i == 5 || i == 10) begin
            n_checks++;
            if (period !== 4'd5 || period_valid !== 1'b1 || locked !== 1'b0) begin
               n_fail++;
               $display("FAIL steady_early i=%0d: got period=%0d valid=%b locked=%b, expected 5 1 0",
                        i, period, period_valid, locked);
            end
         end
      end
      n_checks++;
      if (period !== 4'd5 || locked !== 1'b1 || drop_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL steady_lock: got period=%0d locked=%b dropped_seen=%b, expected 5 1 0",
                  period, locked, drop_seen);
      end
   endtask

   task automatic test_overflow();
      do_reset(1'b1);
      step(1'b1, 1'b1, 1'b0);
      for (int j = 0; j < 20; j++) begin
         step(1'b0, 1'b1, 1'b0);
         n_checks++;
         if (obs_vec !== exp_vec() || overflow !== (j >= 14)) begin
            n_fail++;
            $display("FAIL overflow_wait j=%0d: got %h ovf=%b expected %h ovf=%b",
                     j, obs_vec, overflow, exp_vec(), j >= 14);
         end
      end
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (period_valid !== 1'b0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_restart: got valid=%b ovf=%b, expected 0 1", period_valid, overflow);
      end
      for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (period !== 4'd6 || period_valid !== 1'b1 || locked !== 1'b0 || overflow !== 1'b1 ||
          obs_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL overflow_recover: got period=%0d valid=%b locked=%b ovf=%b, expected 6 1 0 1",
                  period, period_valid, locked, overflow);
      end
   endtask

   task automatic test_max_period();
      do_reset(1'b1);
      for (int i = 0; i <= 30; i++) begin
         step(i % 15 == 0, 1'b1, 1'b0);
         n_checks++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL max_period cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec());
         end
      end
      n_checks++;
      if (period !== 4'd15 || period_valid !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL max_period_final: got period=%0d valid=%b ovf=%b, expected 15 1 0",
                  period, period_valid, overflow);
      end
   endtask

   task automatic test_dropped();
      do_reset(1'b0);
      for (int i = 0; i <= 8; i++) begin
         step(i % 4 == 0, 1'b0, 1'b0);
         n_checks++;
         if (obs_vec !== exp_vec() || dropped !== (i == 8)) begin
            n_fail++;
            $display("FAIL dropped i=%0d: got %h dropped=%b expected %h dropped=%b",
                     i, obs_vec, dropped, exp_vec(), i == 8);
         end
      end
      n_checks++;
      if (period !== 4'd4 || period_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL dropped_hold: got period=%0d valid=%b, expected 4 1", period, period_valid);
      end
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dropped !== 1'b0 || period_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL dropped_pulse_end: got dropped=%b valid=%b, expected 0 1", dropped, period_valid);
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (period_valid !== 1'b0 || obs_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL dropped_consume: got valid=%b outs=%h, expected valid=0 outs=%h",
                  period_valid, obs_vec, exp_vec());
      end
   endtask

   task automatic test_lock_change();
      int rise_at[6] = '{0, 4, 8, 15, 22, 29};
      bit exp_lock[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int k = 0;
      bit t;
      do_reset(1'b1);
      for (int c = 0; c <= 29; c++) begin
         t = (k < 6) && (c == rise_at[k]);
         step(t, 1'b1, 1'b0);
         n_checks++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL lock_change cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec());
         end
         if (t && k > 0) begin
            n_checks++;
            if (locked !== exp_lock[k-1] || int'(period) != rise_at[k] - rise_at[k-1]) begin
               n_fail++;
               $display("FAIL lock_seq cap %0d: got locked=%b period=%0d, expected %b %0d",
                        k, locked, period, exp_lock[k-1], rise_at[k] - rise_at[k-1]);
            end
         end
         if (t) k++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (obs_vec !== '0 || state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got outs=%h state=%0d, expected 0 0", obs_vec, state_dbg);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (period_valid !== 1'b0 || obs_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid_no_capture: got outs=%h, expected %h", obs_vec, exp_vec());
      end
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (period !== 4'd4 || period_valid !== 1'b1 || obs_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid_first_capture: got period=%0d valid=%b, expected 4 1",
                  period, period_valid);
      end
   endtask

   task automatic test_random();
      int quiet = 0;
      bit t, r, rs;
      do_reset(1'b1);
      for (int i = 0; i < 1500; i++) begin
         if (quiet > 0) begin
            quiet--;
            t = 1'b0;
         end else begin
            if ($urandom_range(0, 40) == 0) quiet = $urandom_range(12, 20);
            t = ($urandom_range(0, 3) == 0);
         end
         r  = ($urandom_range(0, 2) != 0);
         rs = ($urandom_range(0, 299) == 0);
         step(t, r, rs);
         n_checks++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_overflow();
      test_max_period();
      test_dropped();
      test_lock_change();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 11, giving the width of the period counter and the period output.
REQ-002 SHALL have parameter LOCK_COUNT, default 3, giving the number of consecutive equal captures needed for lock; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tickIn, input, 1 bit: tick stream under measurement, one-cycle pulses or a level.
REQ-006 SHALL have port period, output, WIDTH bits: the last captured period in clk cycles.
REQ-007 SHALL have port periodValid, output, 1 bit: period holds an unconsumed capture.
REQ-008 SHALL have port periodReady, input, 1 bit: consumer accepts period.
REQ-009 SHALL have port locked, output, 1 bit: the last LOCK_COUNT captures were equal.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when the counter saturated.
REQ-011 SHALL have port dropped, output, 1 bit: one-cycle pulse when an unconsumed capture is overwritten.

Function
REQ-012 SHALL register tickPrev and detect a rise at a clk edge where tickIn==1 and tickPrev==0; a level held high yields one rise only.
REQ-013 SHALL implement three states: IDLE (no rise yet), MEAS (counting), OVF (counter saturated).
REQ-014 In IDLE, a rise SHALL set count to 1, go to MEAS, and make no capture.
REQ-015 In MEAS with no rise, count SHALL increment by 1 per cycle.
REQ-016 In MEAS with a rise, SHALL load period<=count, set periodValid, and set count to 1.
- Rises at edges k and k+P give period==P, with periodValid high from the cycle after edge k+P.
REQ-017 Minimum measurable period SHALL be 2; back-to-back high cycles count as one rise.
REQ-018 In MEAS with count==2^WIDTH-1 and no rise, SHALL go to OVF, set overflow, clear the match count and locked, and hold count.
REQ-019 In MEAS with count==2^WIDTH-1 and a rise in the same cycle, SHALL capture 2^WIDTH-1 as a valid period, with no overflow.
REQ-020 In OVF, a rise SHALL set count to 1, go to MEAS, and make no capture.
- overflow stays set until rst.
REQ-021 periodValid SHALL clear at an edge where periodValid and periodReady are both high, unless a capture occurs at the same edge; then it stays high and period takes the new value.
REQ-022 A capture while periodValid==1 and periodReady==0 SHALL overwrite period, keep periodValid high, and pulse dropped for one cycle.
REQ-023 periodReady while periodValid==0 SHALL have no effect.
REQ-024 On each capture, SHALL update the 4-bit saturating matchCount:
- 1 on the first capture after IDLE or OVF, or when the new value differs from the previous capture;
- otherwise +1, saturating at LOCK_COUNT.
REQ-025 locked SHALL equal (matchCount>=LOCK_COUNT), registered, and change only at a capture, on overflow, or at reset.

Reset
REQ-026 While rst is high at a clk edge, SHALL set state=IDLE, count=0, period=0, periodValid=0, locked=0, overflow=0, dropped=0, matchCount=0, tickPrev=1.
- Because tickPrev resets to 1, a tickIn already high at reset release is not a rise.
REQ-027 rst SHALL take priority over every other event, including a rise or a handshake at the same edge, and SHALL abort any measurement in progress.

Verification
REQ-028 Drive 1-cycle tickIn pulses every 5 cycles, periodReady=1 -> first capture period=5 on the second pulse; locked=1 after the 3rd capture; dropped never pulses.
REQ-029 With WIDTH=4, pulse once then hold tickIn low for 20 cycles -> overflow=1 when count reaches 15; the next pulse makes no capture; the pulse after it (period 6) gives period=6, locked=0.
REQ-030 With WIDTH=4, place rises exactly 15 cycles apart -> period=15, overflow stays 0.
REQ-031 Period 4 with periodReady=0 -> second capture pulses dropped; period still 4; periodValid stays 1; a single periodReady cycle clears it.
REQ-032 Periods 4,4,7,7,7 -> locked goes 0,0,0,0,1, since the 7 resets matchCount to 1.
REQ-033 Assert rst mid-measurement and while tickIn is high -> all outputs 0 next cycle; no rise until tickIn goes low then high; then two further rises produce the first capture.
